// File: rtl/puf_challenge_sequencer.sv
// rtl/puf_challenge_sequencer.sv - PUF array challenge sequencer streaming {err,challenge,response} records
// Optional build macro: PUF_MAJORITY_EN (three evaluations per challenge, bitwise majority vote).
module puf_challenge_sequencer #(
    parameter int CHAL_W         = 8,
    parameter int RESP_W         = 8,
    parameter int EN_W           = 32,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clock,
    input  logic                     computer_reset,
    input  logic                     start,
    input  logic [CHAL_W-1:0]        chal_first,
    input  logic [CHAL_W:0]          chal_count,
    input  logic [EN_W-1:0]          enable_mask,
    output logic [EN_W-1:0]          puf_enable,
    output logic [CHAL_W-1:0]        puf_challenge,
    input  logic [RESP_W-1:0]        puf_out,
    input  logic                     puf_all_done,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [RESP_W+CHAL_W:0]   resp_data,
    output logic                     busy,
    output logic                     run_done
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_EMIT    = 3'd4;

    logic [2:0]        state;
    logic              done_meta;
    logic              done_s;
    logic [EN_W-1:0]   mask_q;
    logic [CHAL_W:0]   remaining;
    logic [SW-1:0]     settle_cnt;
    logic [TW-1:0]     tmo_cnt;
    logic              eval_err;
    logic [RESP_W-1:0] eval_resp;
    logic              settle_ok;
    logic              tmo_hit;

`ifdef PUF_MAJORITY_EN
    logic [1:0]        eval_idx;
    logic [RESP_W-1:0] vote0;
    logic [RESP_W-1:0] vote1;
    logic              err_acc;
`endif

    assign settle_ok  = (settle_cnt == SW'(SETTLE_CYCLES - 1));
    assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign puf_enable = (state == S_RUN) ? mask_q : '0;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clock or negedge computer_reset) begin
        if (!computer_reset) begin
            state         <= S_IDLE;
            done_meta     <= 1'b0;
            done_s        <= 1'b0;
            mask_q        <= '0;
            remaining     <= '0;
            settle_cnt    <= '0;
            tmo_cnt       <= '0;
            eval_err      <= 1'b0;
            eval_resp     <= '0;
            puf_challenge <= '0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            run_done      <= 1'b0;
`ifdef PUF_MAJORITY_EN
            eval_idx      <= '0;
            vote0         <= '0;
            vote1         <= '0;
            err_acc       <= 1'b0;
`endif
        end else begin
            done_meta <= puf_all_done;
            done_s    <= done_meta;
            run_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && chal_count != '0) begin
                        mask_q        <= enable_mask;
                        remaining     <= chal_count;
                        puf_challenge <= chal_first;
                        settle_cnt    <= '0;
                        tmo_cnt       <= '0;
`ifdef PUF_MAJORITY_EN
                        eval_idx      <= '0;
                        err_acc       <= 1'b0;
`endif
                        state         <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (!settle_ok)
                        settle_cnt <= settle_cnt + SW'(1);
                    if (tmo_hit) begin
                        eval_err  <= 1'b1;
                        eval_resp <= '0;
                        state     <= S_CAPTURE;
                    end else if (settle_ok && !done_s) begin
                        // A done still high from the previous evaluation holds us here.
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (done_s) begin
                        eval_err  <= 1'b0;
                        eval_resp <= puf_out;
                        state     <= S_CAPTURE;
                    end else if (tmo_hit) begin
                        eval_err  <= 1'b1;
                        eval_resp <= '0;
                        state     <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
`ifdef PUF_MAJORITY_EN
                    if (eval_idx != 2'd2) begin
                        if (eval_idx == 2'd0)
                            vote0 <= eval_resp;
                        else
                            vote1 <= eval_resp;
                        err_acc    <= err_acc | eval_err;
                        eval_idx   <= eval_idx + 2'd1;
                        settle_cnt <= '0;
                        tmo_cnt    <= '0;
                        state      <= S_SETUP;
                    end else begin
                        resp_data  <= {err_acc | eval_err, puf_challenge,
                                       (vote0 & vote1) | (vote0 & eval_resp) | (vote1 & eval_resp)};
                        resp_valid <= 1'b1;
                        eval_idx   <= '0;
                        err_acc    <= 1'b0;
                        state      <= S_EMIT;
                    end
`else
                    resp_data  <= {eval_err, puf_challenge, eval_resp};
                    resp_valid <= 1'b1;
                    state      <= S_EMIT;
`endif
                end
                S_EMIT: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        remaining  <= remaining - (CHAL_W+1)'(1);
                        if (remaining == (CHAL_W+1)'(1)) begin
                            run_done <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            puf_challenge <= puf_challenge + CHAL_W'(1);
                            settle_cnt    <= '0;
                            tmo_cnt       <= '0;
                            state         <= S_SETUP;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// tb/tb_puf_challenge_sequencer.sv - scoreboard bench with array model for puf_challenge_sequencer
module tb_puf_challenge_sequencer;

    localparam int CW     = 8;
    localparam int RW     = 8;
    localparam int EW     = 32;
    localparam int SETTLE = 16;
    localparam int TMO    = 4096;
`ifdef PUF_MAJORITY_EN
    localparam int NEVAL  = 3;
`else
    localparam int NEVAL  = 1;
`endif

    logic              clock = 0;
    logic              computer_reset = 0;
    logic              start = 0;
    logic [CW-1:0]     chal_first = 0;
    logic [CW:0]       chal_count = 0;
    logic [EW-1:0]     enable_mask = 0;
    logic [EW-1:0]     puf_enable;
    logic [CW-1:0]     puf_challenge;
    logic [RW-1:0]     puf_out = 0;
    logic              puf_all_done = 0;
    logic              resp_valid;
    logic              resp_ready = 1;
    logic [RW+CW:0]    resp_data;
    logic              busy;
    logic              run_done;

    puf_challenge_sequencer #(
        .CHAL_W(CW), .RESP_W(RW), .EN_W(EW),
        .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .computer_reset(computer_reset), .start(start),
        .chal_first(chal_first), .chal_count(chal_count), .enable_mask(enable_mask),
        .puf_enable(puf_enable), .puf_challenge(puf_challenge), .puf_out(puf_out),
        .puf_all_done(puf_all_done), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .busy(busy), .run_done(run_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;
    logic [RW+CW:0] sb[$];
    int  run_done_cnt = 0;
    int  pulses = 0;
    int  ready_mode = 0;
    int  model_delay = 10;
    logic [7:0] model_key = 0;
    bit  hang_en = 0;
    logic [7:0] hang_chal = 0;
    logic [EW-1:0] cur_mask = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    function automatic logic [7:0] eval_val(input logic [7:0] c, input int k);
        logic [7:0] x;
        x = c ^ model_key;
`ifdef PUF_MAJORITY_EN
        case (k)
            0: return x ^ 8'h0F;
            1: return x ^ 8'h3C;
            default: return x ^ 8'h33;
        endcase
`else
        if (k < 0) return 8'h00;
        return x;
`endif
    endfunction

    function automatic logic [7:0] expected_resp(input logic [7:0] c);
        logic [7:0] a, b, d;
        if (NEVAL == 1) return eval_val(c, 0);
        a = eval_val(c, 0);
        b = eval_val(c, 1);
        d = eval_val(c, 2);
        return (a & b) | (a & d) | (b & d);
    endfunction

    // Array model: asserts done model_delay cycles into each enable pulse, drops it with enable.
    initial begin
        bit en_prev = 0;
        int cnt = 0;
        int k = 0;
        forever begin
            @(posedge clock); #1;
            if (puf_enable != 0) begin
                if (!en_prev) begin
                    cnt = 0;
                    k = pulses % NEVAL;
                    pulses++;
                end
                cnt++;
                if (cnt >= model_delay && !(hang_en && puf_challenge == hang_chal)) begin
                    puf_all_done = 1;
                    puf_out = eval_val(puf_challenge, k);
                end
                en_prev = 1;
            end else begin
                puf_all_done = 0;
                en_prev = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock); #1;
            case (ready_mode)
                0: resp_ready = 1;
                1: resp_ready = ($urandom % 4) != 0;
                default: resp_ready = 0;
            endcase
        end
    end

    // Monitor: pops scoreboard on every transfer, checks hold and enable rules.
    initial begin
        bit prev_v = 0, prev_r = 0;
        logic [RW+CW:0] prev_d = 0;
        logic [EW-1:0] prev_en = 0;
        logic [CW-1:0] prev_ch = 0;
        logic [RW+CW:0] exp;
        forever begin
            @(negedge clock);
            if (!computer_reset) begin
                prev_v = 0;
                prev_en = 0;
            end else begin
                if (prev_v && !prev_r) begin
                    check("hold_valid", resp_valid, 1);
                    check("hold_data", resp_data, prev_d);
                end
                check("enable_value", (puf_enable == 0 || puf_enable == cur_mask), 1);
                if (prev_en != 0 && puf_enable != 0)
                    check("chal_stable_run", puf_challenge, prev_ch);
                if (resp_valid && resp_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_record: got %0h required none", resp_data);
                    end else begin
                        exp = sb.pop_front();
                        check("record", resp_data, exp);
                    end
                end
                if (run_done) run_done_cnt++;
                prev_v = resp_valid;
                prev_r = resp_ready;
                prev_d = resp_data;
                prev_en = puf_enable;
                prev_ch = puf_challenge;
            end
        end
    end

    task automatic do_run(input logic [7:0] first, input int count, input logic [7:0] key,
                          input int dly, input bit hg, input logic [7:0] hc);
        int rd0, p0, cycles, cap;
        logic [7:0] c;
        logic [EW-1:0] mask;
        mask = $urandom | 32'h1;
        model_key = key; model_delay = dly; hang_en = hg; hang_chal = hc; cur_mask = mask;
        for (int i = 0; i < count; i++) begin
            c = first + 8'(i);
            if (hg && c == hc) sb.push_back({1'b1, c, 8'h00});
            else               sb.push_back({1'b0, c, expected_resp(c)});
        end
        rd0 = run_done_cnt;
        p0 = pulses;
        @(posedge clock); #1;
        start = 1; chal_first = first; chal_count = 9'(count); enable_mask = mask;
        @(posedge clock); #1;
        start = 0; chal_first = $urandom; chal_count = 9'($urandom_range(1, 5)); enable_mask = $urandom;
        repeat (3) @(posedge clock);
        #1 start = 1;
        @(posedge clock); #1 start = 0;
        cap = count * (TMO * NEVAL + 400) + 200;
        cycles = 0;
        while (busy && cycles < cap) begin
            @(posedge clock); #1;
            cycles++;
        end
        check("run_finished", busy, 0);
        @(negedge clock); #1;
        check("records_drained", sb.size(), 0);
        check("run_done_once", run_done_cnt - rd0, 1);
        check("enable_pulses", pulses - p0, count * NEVAL);
        sb.delete();
    endtask

    initial begin
        int cycles;
        bit any_busy;
        logic [CW-1:0] held_ch;
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        int cycles;
        bit any_busy;
        int rd0;
        logic [CW-1:0] held_ch;
        repeat (3) @(posedge clock);
        #1;
        check("rst_enable", puf_enable, 0);
        check("rst_challenge", puf_challenge, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_data", resp_data, 0);
        check("rst_busy", busy, 0);
        check("rst_run_done", run_done, 0);
        computer_reset = 1;

        // Directed: {0,10,B5},{0,11,B4},{0,12,B7} in the single-evaluation build.
        do_run(8'h10, 3, 8'hA5, 50, 0, 0);
        do_run(8'hFE, 3, $urandom, 20, 0, 0);
        // Timeout on the first challenge, normal result on the next.
        do_run(8'h40, 2, $urandom, 10, 1, 8'h40);

        // Backpressure: ready held low 20 cycles while a record is offered.
        ready_mode = 2;
        fork
            do_run(8'h77, 2, $urandom, 5, 0, 0);
            begin
                cycles = 0;
                while (!resp_valid && cycles < 2000) begin
                    @(posedge clock); #1;
                    cycles++;
                end
                check("bp_valid_seen", resp_valid, 1);
                held_ch = puf_challenge;
                repeat (20) @(posedge clock);
                #1;
                check("bp_valid_held", resp_valid, 1);
                check("bp_no_setup", puf_challenge, held_ch);
                check("bp_enable_low", puf_enable, 0);
                ready_mode = 0;
            end
        join

        // Zero-length run is ignored.
        rd0 = run_done_cnt;
        @(posedge clock); #1;
        start = 1; chal_count = 0;
        @(posedge clock); #1 start = 0;
        any_busy = 0;
        repeat (10) begin
            @(posedge clock); #1;
            any_busy |= busy;
        end
        check("count0_idle", any_busy, 0);
        check("count0_no_done", run_done_cnt - rd0, 0);

        ready_mode = 1;
        for (int r = 0; r < 6; r++)
            do_run($urandom, $urandom_range(1, 5), $urandom, $urandom_range(1, 40), 0, 0);
        ready_mode = 0;

        // Reset during RUN aborts immediately.
        model_delay = 30; hang_en = 0; cur_mask = 32'hFFFF_0001;
        @(posedge clock); #1;
        start = 1; chal_first = 8'h20; chal_count = 3; enable_mask = cur_mask;
        @(posedge clock); #1 start = 0;
        cycles = 0;
        while (puf_enable == 0 && cycles < 500) begin
            @(posedge clock); #1;
            cycles++;
        end
        check("rst_run_reached", puf_enable, cur_mask);
        #2 computer_reset = 0;
        #1;
        check("arst_enable", puf_enable, 0);
        check("arst_valid", resp_valid, 0);
        check("arst_busy", busy, 0);
        sb.delete();
        repeat (2) @(posedge clock);
        #1 computer_reset = 1;
        do_run(8'h33, 2, $urandom, 12, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
